// File: rtl/sim_mailbox_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sim_mailbox_pkg : shared types and helpers for the result mailbox monitor
// rev 1.0
// ----------------------------------------------------------------------------
package sim_mailbox_pkg;

   localparam logic [31:0] MB_OFF_FLAG   = 32'h00;
   localparam logic [31:0] MB_OFF_FINISH = 32'h04;
   localparam logic [31:0] MB_OFF_TYPE   = 32'h08;
   localparam logic [31:0] MB_OFF_INDEX  = 32'h0C;
   localparam logic [31:0] MB_OFF_RESULT = 32'h10;
   localparam logic [31:0] MB_OFF_EXPECT = 32'h14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } mb_state_t;

   typedef struct packed {
      logic [31:0] err_type;
      logic [31:0] err_index;
      logic [31:0] err_result;
      logic [31:0] err_expect;
   } mb_err_t;

   function automatic logic [31:0] byte_swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sim_mailbox_log_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sim_mailbox_log_fifo : synchronous FIFO with sticky overflow on dropped push
// rev 1.0
// ----------------------------------------------------------------------------
module sim_mailbox_log_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot the push is about to fill
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
            wr_ptr                 <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_push) overflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sim_result_mailbox_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sim_result_mailbox_monitor : snoops mailbox writes, tracks per-channel
// pass/fail, logs failures and flags a global timeout.  rev 1.0
// ----------------------------------------------------------------------------
module sim_result_mailbox_monitor
   import sim_mailbox_pkg::*;
#(
   parameter logic [31:0] P_BASE_ADDR      = 32'h0002_0000,
   parameter int          P_CHANNELS       = 1,
   parameter int          P_CH_STRIDE_W    = 5,
   parameter int          P_BYTE_SWAP      = 1,
   parameter int          P_LOG_DEPTH      = 4,
   parameter logic [31:0] P_TIMEOUT_CYCLES = 32'd750000,
   localparam int         CH_W             = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
   input  logic                  iCLOCK,
   input  logic                  iRESET_SYNC,
   input  logic                  iMEMORY_REQ,
   input  logic                  iMEMORY_LOCK,
   input  logic [1:0]            iMEMORY_ORDER,
   input  logic                  iMEMORY_RW,
   input  logic [31:0]           iMEMORY_ADDR,
   input  logic [31:0]           iMEMORY_DATA,
   output logic [P_CHANNELS-1:0] oCH_DONE,
   output logic [P_CHANNELS-1:0] oCH_FAIL,
   output logic                  oALL_DONE,
   output logic                  oPASS,
   output logic                  oTIMEOUT,
   output logic                  oPROTOCOL_ERR,
   input  logic                  iLOG_RD,
   output logic                  oLOG_VALID,
   output logic [128+CH_W-1:0]   oLOG_DATA,
   output logic                  oLOG_OVERFLOW
);

   logic [31:0]                  addr_off;
   logic [31:0]                  ch_idx;
   logic [31:0]                  word_off;
   logic [31:0]                  wr_word;
   logic [CH_W-1:0]              sel_ch;
   logic                         bus_wr;
   logic                         wr_flag;
   logic                         wr_finish;
   logic                         wr_type;
   logic                         wr_index;
   logic                         wr_result;
   logic                         wr_expect;
   logic                         mb_write;
   logic [P_CHANNELS-1:0]        flag_vec;
   logic [P_CHANNELS-1:0][127:0] err_vec;
   logic                         log_push;
   logic                         log_empty;
   logic [31:0]                  tmo_cnt;

   assign addr_off = iMEMORY_ADDR - P_BASE_ADDR;
   assign ch_idx   = addr_off >> P_CH_STRIDE_W;
   assign word_off = addr_off & ((32'd1 << P_CH_STRIDE_W) - 32'd1);
   assign sel_ch   = ch_idx[CH_W-1:0];
   assign wr_word  = (P_BYTE_SWAP != 0) ? byte_swap32(iMEMORY_DATA) : iMEMORY_DATA;

   assign bus_wr    = iMEMORY_REQ && !iMEMORY_LOCK && (iMEMORY_ORDER == 2'b10) && iMEMORY_RW &&
                      (iMEMORY_ADDR >= P_BASE_ADDR) && (ch_idx < 32'(P_CHANNELS));
   assign wr_flag   = bus_wr && (word_off == MB_OFF_FLAG);
   assign wr_finish = bus_wr && (word_off == MB_OFF_FINISH);
   assign wr_type   = bus_wr && (word_off == MB_OFF_TYPE);
   assign wr_index  = bus_wr && (word_off == MB_OFF_INDEX);
   assign wr_result = bus_wr && (word_off == MB_OFF_RESULT);
   assign wr_expect = bus_wr && (word_off == MB_OFF_EXPECT);
   assign mb_write  = wr_flag | wr_finish | wr_type | wr_index | wr_result | wr_expect;

   for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
      mb_state_t state;
      mb_state_t state_nxt;
      mb_err_t   err;
      logic      flag;
      logic      hit;

      assign hit = mb_write && (sel_ch == CH_W'(g));

      always_ff @(posedge iCLOCK) begin
         if (iRESET_SYNC) state <= IDLE;
         else             state <= state_nxt;
      end

      always_comb begin
         state_nxt = state;
         if (hit && (state == IDLE || state == RUN)) begin
            if (wr_finish) state_nxt = flag ? PASS : FAIL;
            else           state_nxt = RUN;
         end
      end

      // flag is taken from the raw bus lane, never swapped
      always_ff @(posedge iCLOCK) begin
         if (iRESET_SYNC) begin
            flag <= 1'b0;
            err  <= '0;
         end else if (hit) begin
            if (wr_flag)   flag           <= iMEMORY_DATA[24];
            if (wr_type)   err.err_type   <= wr_word;
            if (wr_index)  err.err_index  <= wr_word;
            if (wr_result) err.err_result <= wr_word;
            if (wr_expect) err.err_expect <= wr_word;
         end
      end

      assign oCH_DONE[g] = (state == PASS) || (state == FAIL);
      assign oCH_FAIL[g] = (state == FAIL);
      assign flag_vec[g] = flag;
      assign err_vec[g]  = err;
   end

   assign oALL_DONE = &oCH_DONE;
   assign oPASS     = oALL_DONE && ~|oCH_FAIL;
   assign log_push  = wr_finish && !oCH_DONE[sel_ch] && !flag_vec[sel_ch];

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         tmo_cnt       <= '0;
         oTIMEOUT      <= 1'b0;
         oPROTOCOL_ERR <= 1'b0;
      end else begin
         if (!oALL_DONE && (tmo_cnt < P_TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 32'd1;
         if ((P_TIMEOUT_CYCLES != 32'd0) && (tmo_cnt == P_TIMEOUT_CYCLES)) oTIMEOUT <= 1'b1;
         if (wr_finish && oCH_DONE[sel_ch]) oPROTOCOL_ERR <= 1'b1;
      end
   end

   sim_mailbox_log_fifo #(
      .WIDTH (128 + CH_W),
      .DEPTH (P_LOG_DEPTH)
   ) u_log (
      .clk      (iCLOCK),
      .rst      (iRESET_SYNC),
      .push     (log_push),
      .pop      (iLOG_RD),
      .din      ({sel_ch, err_vec[sel_ch]}),
      .dout     (oLOG_DATA),
      .empty    (log_empty),
      .overflow (oLOG_OVERFLOW)
   );

   assign oLOG_VALID = !log_empty;

endmodule
`default_nettype wire

// File: tb/tb_sim_result_mailbox_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sim_result_mailbox_monitor : scoreboard bench with a behavioural model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_sim_result_mailbox_monitor;

   localparam int          NCH   = 4;
   localparam int          DEPTH = 2;
   localparam int          TMO   = 100;
   localparam logic [31:0] BASE  = 32'h0002_0000;

   logic         clk    = 1'b0;
   logic         rst    = 1'b1;
   logic         req    = 1'b0;
   logic         lock   = 1'b0;
   logic [1:0]   order  = 2'b11;
   logic         rw     = 1'b0;
   logic [31:0]  addr   = '0;
   logic [31:0]  data   = '0;
   logic         log_rd = 1'b0;

   logic [NCH-1:0] ch_done;
   logic [NCH-1:0] ch_fail;
   logic           all_done;
   logic           pass;
   logic           timeout;
   logic           perr;
   logic           log_valid;
   logic [129:0]   log_data;
   logic           ovf;

   int compared   = 0;
   int mismatched = 0;
   int pop_mode   = 0;
   bit force_pop  = 1'b0;

   always #5 clk = ~clk;

   sim_result_mailbox_monitor #(
      .P_BASE_ADDR      (BASE),
      .P_CHANNELS       (NCH),
      .P_CH_STRIDE_W    (5),
      .P_BYTE_SWAP      (1),
      .P_LOG_DEPTH      (DEPTH),
      .P_TIMEOUT_CYCLES (32'(TMO))
   ) dut (
      .iCLOCK        (clk),
      .iRESET_SYNC   (rst),
      .iMEMORY_REQ   (req),
      .iMEMORY_LOCK  (lock),
      .iMEMORY_ORDER (order),
      .iMEMORY_RW    (rw),
      .iMEMORY_ADDR  (addr),
      .iMEMORY_DATA  (data),
      .oCH_DONE      (ch_done),
      .oCH_FAIL      (ch_fail),
      .oALL_DONE     (all_done),
      .oPASS         (pass),
      .oTIMEOUT      (timeout),
      .oPROTOCOL_ERR (perr),
      .iLOG_RD       (log_rd),
      .oLOG_VALID    (log_valid),
      .oLOG_DATA     (log_data),
      .oLOG_OVERFLOW (ovf)
   );

   task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] swap(input logic [31:0] d);
      return (d << 24) | ((d << 8) & 32'h00FF_0000) | ((d >> 8) & 32'h0000_FF00) | (d >> 24);
   endfunction

   // ---------------- behavioural reference model ----------------
   logic [NCH-1:0] m_done, m_fail, m_flag;
   logic [31:0]    m_ty [NCH];
   logic [31:0]    m_ix [NCH];
   logic [31:0]    m_rs [NCH];
   logic [31:0]    m_ex [NCH];
   int             m_cnt, m_count;
   bit             m_to, m_perr, m_ovf;
   logic [129:0]   exp_q [$];
   bit             m_popped, m_pushed;
   logic [129:0]   m_entry;
   int unsigned    m_diff, m_c, m_off;

   initial begin
      m_done = '0; m_fail = '0; m_flag = '0;
      m_cnt = 0; m_count = 0; m_to = 0; m_perr = 0; m_ovf = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_done = '0; m_fail = '0; m_flag = '0;
            for (int i = 0; i < NCH; i++) begin
               m_ty[i] = '0; m_ix[i] = '0; m_rs[i] = '0; m_ex[i] = '0;
            end
            m_cnt = 0; m_count = 0; m_to = 0; m_perr = 0; m_ovf = 0;
            exp_q.delete();
         end else begin
            m_popped = log_rd && (m_count > 0);
            m_pushed = 0;
            if (m_cnt == TMO) m_to = 1;
            if (m_done != {NCH{1'b1}} && m_cnt < TMO) m_cnt++;
            if (req && !lock && order == 2'b10 && rw && addr >= BASE) begin
               m_diff = addr - BASE;
               m_c    = m_diff / 32;
               m_off  = m_diff % 32;
               if (m_c < NCH) begin
                  case (m_off)
                     0:  m_flag[m_c] = data[24];
                     4:  if (m_done[m_c]) m_perr = 1;
                         else begin
                            m_done[m_c] = 1'b1;
                            m_fail[m_c] = !m_flag[m_c];
                            if (!m_flag[m_c]) begin
                               m_entry  = {m_c[1:0], m_ty[m_c], m_ix[m_c], m_rs[m_c], m_ex[m_c]};
                               m_pushed = 1;
                            end
                         end
                     8:  m_ty[m_c] = swap(data);
                     12: m_ix[m_c] = swap(data);
                     16: m_rs[m_c] = swap(data);
                     20: m_ex[m_c] = swap(data);
                     default: ;
                  endcase
               end
            end
            if (m_pushed) begin
               if (m_count == DEPTH && !m_popped) m_ovf = 1;
               else begin
                  exp_q.push_back(m_entry);
                  m_count++;
               end
            end
            if (m_popped) m_count--;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      bit want_pop;
      forever begin
         @(negedge clk);
         #1;
         chk("ch_done",   ch_done,   m_done);
         chk("ch_fail",   ch_fail,   m_fail);
         chk("all_done",  all_done,  &m_done);
         chk("pass",      pass,      (&m_done) && !(|m_fail));
         chk("timeout",   timeout,   m_to);
         chk("proto_err", perr,      m_perr);
         chk("overflow",  ovf,       m_ovf);
         chk("log_valid", log_valid, m_count > 0);
         if (log_valid) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL log_extra: got entry %h expected none", log_data);
            end else begin
               chk("log_data", log_data, exp_q[0]);
            end
         end
         if (rst)                want_pop = 0;
         else if (pop_mode == 1) want_pop = ($urandom % 3 == 0);
         else                    want_pop = force_pop;
         if (want_pop && m_count > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
         log_rd = want_pop;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic r, input logic lk, input logic [1:0] o, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = r; lock = lk; order = o; rw = w; addr = a; data = d;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b0, 2'b10, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic settle();
      idle(1);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 1'b1; lock = 1'b0; order = 2'b10; rw = 1'b1; addr = BASE + 32'h4; data = $urandom;
      @(negedge clk);
      rst = 1'b0;
      req = 1'b0; order = 2'b11; rw = 1'b0;
   endtask

   task automatic rand_cycle();
      int unsigned r, c, o;
      r = $urandom % 10;
      c = $urandom % NCH;
      o = ($urandom % 8) * 4;
      case (r)
         0, 1: idle(1);
         2: drive(1'b1, 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                  BASE + 32'(c * 32 + o), $urandom);
         3: drive(1'b1, 1'b0, 2'b10, 1'b1,
                  ($urandom % 2) ? BASE - 32'(4 + ($urandom % 64) * 4) : BASE + 32'(128 + ($urandom % 64) * 4),
                  $urandom);
         default: wr(BASE + 32'(c * 32 + o), $urandom);
      endcase
   endtask

   initial begin : stim
      int len;
      // flag=1 then finish -> channel passes, nothing logged
      do_reset();
      pop_mode = 0;
      wr(BASE + 32'h00, 32'h0100_0000);
      wr(BASE + 32'h04, 32'h0);
      settle();
      chk("t1_done", ch_done, 4'b0001);
      chk("t1_valid", log_valid, 1'b0);

      // failing channel 2 with swapped fields
      wr(BASE + 32'h48, 32'h0300_0000);
      wr(BASE + 32'h4C, 32'h0700_0000);
      wr(BASE + 32'h50, 32'hEFBE_ADDE);
      wr(BASE + 32'h54, 32'h0DF0_ADBA);
      wr(BASE + 32'h40, 32'h0);
      wr(BASE + 32'h44, 32'h0);
      settle();
      chk("t2_fail", ch_fail, 4'b0100);
      chk("t2_valid", log_valid, 1'b1);
      chk("t2_data", log_data, {2'd2, 32'h3, 32'h7, 32'hDEAD_BEEF, 32'hBAAD_F00D});

      // remaining channels pass
      wr(BASE + 32'h20, 32'h0100_0000);
      wr(BASE + 32'h24, 32'h0);
      wr(BASE + 32'h60, 32'h0100_0000);
      wr(BASE + 32'h64, 32'h0);
      settle();
      chk("t3_done", ch_done, 4'b1111);
      chk("t3_fail", ch_fail, 4'b0100);
      chk("t3_all", all_done, 1'b1);
      chk("t3_pass", pass, 1'b0);

      // repeat finish on a done channel
      wr(BASE + 32'h04, 32'h0);
      settle();
      chk("t6_perr", perr, 1'b1);
      chk("t6_done", ch_done, 4'b1111);

      // locked / wrong-size / read finishes are ignored
      do_reset();
      drive(1'b1, 1'b1, 2'b10, 1'b1, BASE + 32'h04, 32'h0);
      drive(1'b1, 1'b0, 2'b01, 1'b1, BASE + 32'h04, 32'h0);
      drive(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'h04, 32'h0);
      settle();
      chk("t6_ignored", ch_done, 4'b0000);
      wr(BASE + 32'h00, 32'h0100_0000);
      wr(BASE + 32'h04, 32'h0);
      wr(BASE + 32'h24, 32'h0);
      settle();
      chk("t6_run", ch_done, 4'b0011);
      do_reset();
      #2;
      chk("t6_rst_done", ch_done, 4'b0000);
      chk("t6_rst_valid", log_valid, 1'b0);

      // overflow: three failures, depth two, no pops
      do_reset();
      wr(BASE + 32'h04, 32'h0);
      wr(BASE + 32'h24, 32'h0);
      wr(BASE + 32'h44, 32'h0);
      settle();
      chk("t4_ovf", ovf, 1'b1);
      chk("t4_valid", log_valid, 1'b1);

      // full with push and pop in the same cycle
      do_reset();
      wr(BASE + 32'h04, 32'h0);
      wr(BASE + 32'h24, 32'h0);
      wr(BASE + 32'h44, 32'h0);
      force_pop = 1'b1;
      idle(1);
      force_pop = 1'b0;
      #2;
      chk("t4b_ovf", ovf, 1'b0);
      force_pop = 1'b1;
      idle(2);
      force_pop = 1'b0;
      #2;
      chk("t4b_one_left", log_valid, 1'b1);
      force_pop = 1'b1;
      idle(2);
      force_pop = 1'b0;
      #2;
      chk("t4b_empty", log_valid, 1'b0);

      // timeout with no finishes
      do_reset();
      idle(95);
      #2;
      chk("t5_early", timeout, 1'b0);
      idle(15);
      #2;
      chk("t5_fired", timeout, 1'b1);

      // all channels finish before the limit
      do_reset();
      idle(40);
      for (int c = 0; c < NCH; c++) begin
         wr(BASE + 32'(c * 32), 32'h0100_0000);
         wr(BASE + 32'(c * 32 + 4), 32'h0);
      end
      idle(120);
      #2;
      chk("t5_no_timeout", timeout, 1'b0);
      chk("t5_pass", pass, 1'b1);

      // randomized episodes
      for (int e = 0; e < 30; e++) begin
         do_reset();
         pop_mode = int'($urandom % 2);
         len = 40 + int'($urandom % 140);
         for (int k = 0; k < len; k++) begin
            if ($urandom % 60 == 0) do_reset();
            else rand_cycle();
         end
      end

      pop_mode = 1;
      idle(12);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
